nonce_reporter: RTL

Result-path framer between the hash cores and the `uart_tx` byte transmitter. It buffers found 32-bit nonces in a small FIFO and emits each one to the host as a fixed-length byte frame. Bytes go out over the `uart_tx` start/busy handshake. It is the FPGA-to-host counterpart of the work-receive path fed by `uart_rx`.

---
 rtl/nonce_reporter_pkg.sv | 18 +
 rtl/nonce_reporter_if.sv | 21 ++
 rtl/nonce_fifo.sv | 49 ++++
 rtl/nonce_reporter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/nonce_reporter_pkg.sv
// nonce_reporter_pkg: shared types and constants for the nonce result framer.
// Frame length depends on NONCE_REPORTER_CHECKSUM_EN (see nonce_reporter.sv).
package nonce_reporter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT_HI,
      WAIT_LO
   } state_t;

   localparam int unsigned FRAME_LEN_PLAIN = 5;
   localparam int unsigned FRAME_LEN_CSUM  = 6;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;

endpackage

// File: rtl/nonce_reporter_if.sv
// nonce_reporter_if: nonce push strobe plus uart_tx byte handshake and status.
// slave = framer side, master = producer / uart_tx / host side.
interface nonce_reporter_if;
   logic [31:0] nonce;
   logic        nonce_valid;
   logic        tx_busy;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        overflow;
   logic        idle;

   modport master (
      output nonce, nonce_valid, tx_busy,
      input  tx_data, tx_start, overflow, idle
   );

   modport slave (
      input  nonce, nonce_valid, tx_busy,
      output tx_data, tx_start, overflow, idle
   );
endinterface

// File: rtl/nonce_fifo.sv
// nonce_fifo: 32-bit synchronous FIFO, first-word-fall-through read port.
// Caller must never pop when empty; push-when-full filtering is done by the caller.
module nonce_fifo #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        push,
   input  logic                        pop,
   input  logic [31:0]                 wdata,
   output logic [31:0]                 rdata,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] count
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wdata;
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rptr];
   assign full  = (count == CW'(FIFO_DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/nonce_reporter.sv
// nonce_reporter: buffers found nonces and frames each one as
// SYNC, n[7:0], n[15:8], n[23:16], n[31:24] [, XOR checksum] over uart_tx.
// Optional feature macro: NONCE_REPORTER_CHECKSUM_EN (adds checksum byte).
module nonce_reporter
   import nonce_reporter_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
   input logic             clk,
   input logic             reset_n,
   nonce_reporter_if.slave bus
);
`ifdef NONCE_REPORTER_CHECKSUM_EN
   localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN_CSUM - 1);
`else
   localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN_PLAIN - 1);
`endif

   state_t                     state;
   logic [2:0]                 idx;
   logic [2:0]                 next_idx;
   logic [31:0]                frame;
   logic [7:0]                 next_byte;
   logic [7:0]                 tx_data_q;
   logic                       tx_start_q;
   logic                       overflow_q;
   logic                       push;
   logic                       pop;
   logic                       full;
   logic                       empty;
   logic [31:0]                fifo_rdata;
   logic [$clog2(FIFO_DEPTH):0] count;
`ifdef NONCE_REPORTER_CHECKSUM_EN
   logic [7:0]                 csum;
`endif

   assign pop  = (state == LOAD);
   assign push = bus.nonce_valid && (!full || pop);

   nonce_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .wdata   (bus.nonce),
      .rdata   (fifo_rdata),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   // Select the byte that the next SEND will present.
   always_comb begin
      next_idx  = idx + 3'd1;
      next_byte = SYNC_BYTE;
      case (next_idx)
         3'd1:    next_byte = frame[7:0];
         3'd2:    next_byte = frame[15:8];
         3'd3:    next_byte = frame[23:16];
         3'd4:    next_byte = frame[31:24];
`ifdef NONCE_REPORTER_CHECKSUM_EN
         3'd5:    next_byte = csum;
`endif
         default: next_byte = SYNC_BYTE;
      endcase
   end

   // Frame FSM. tx_data/tx_start are loaded on the transition into SEND so
   // they are registered yet valid exactly during the SEND cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         idx        <= '0;
         frame      <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
`ifdef NONCE_REPORTER_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         tx_start_q <= 1'b0;
         case (state)
            IDLE: begin
               if (!empty) state <= LOAD;
            end
            LOAD: begin
               frame      <= fifo_rdata;
               idx        <= '0;
`ifdef NONCE_REPORTER_CHECKSUM_EN
               csum       <= '0;
`endif
               tx_data_q  <= SYNC_BYTE;
               tx_start_q <= 1'b1;
               state      <= SEND;
            end
            SEND: begin
`ifdef NONCE_REPORTER_CHECKSUM_EN
               if (idx != 3'd0 && idx != 3'd5) csum <= csum ^ tx_data_q;
`endif
               state <= WAIT_HI;
            end
            WAIT_HI: begin
               if (bus.tx_busy) state <= WAIT_LO;
            end
            WAIT_LO: begin
               if (!bus.tx_busy) begin
                  if (idx == LAST_IDX) begin
                     state <= IDLE;
                  end else begin
                     idx        <= next_idx;
                     tx_data_q  <= next_byte;
                     tx_start_q <= 1'b1;
                     state      <= SEND;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky drop flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          overflow_q <= 1'b0;
      else if (bus.nonce_valid && !push)     overflow_q <= 1'b1;
   end

   assign bus.tx_data  = tx_data_q;
   assign bus.tx_start = tx_start_q;
   assign bus.overflow = overflow_q;
   assign bus.idle     = (count == '0) && (state == IDLE);

endmodule
